// File: rtl/mem_port_arbiter.sv
// Purpose: round-robin arbiter sharing one fixed-latency memory port between the CPU and DMA requesters.
// Latency: a read granted in cycle t returns x_rvalid in t+2+MEM_LAT; a write is issued in t+1.
// Backpressure: one access in flight; x_gnt is only offered in IDLE, so a requester holds req until granted.
//
// Ports:
//   clock, resetn                 rising-edge clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata     CPU request and fields (held stable until c_gnt)
//   c_gnt                         CPU request accepted this cycle (combinational)
//   c_rvalid/c_rdata              CPU read data, one-cycle valid pulse; rdata holds until the next CPU read
//   d_*                           DMA/loader equivalents of the c_* ports
//   m_en/m_we/m_addr/m_wdata      memory strobe, write enable, word-aligned byte address, write data
//   m_rdata                       memory read data, valid MEM_LAT cycles after the m_en cycle
//   busy                          arbiter not idle
//   owner                         current/last owner (0 = CPU, 1 = DMA), updated on grant
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              owner
);

    // The counter only ever holds MEM_LAT-1 down to 0.
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                last_q;     // id of the most recent grant; the other port wins a tie
    logic                owner_q;
    logic                we_q;
    logic [ADDR_W-3:0]   addr_q;     // byte-offset bits are never used, so they are not stored
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   c_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                grant_any;
    logic                last_wait;

    assign grant_any = c_gnt | d_gnt;
    assign last_wait = (state_q == WAIT) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        c_gnt   = 1'b0;
        d_gnt   = 1'b0;
        m_en    = 1'b0;
        m_we    = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by resetn so no grant is advertised while reset is held.
                if (resetn) begin
                    if (c_req && (!d_req || last_q)) begin
                        c_gnt = 1'b1;
                    end else if (d_req) begin
                        d_gnt = 1'b1;
                    end
                end
                if (c_gnt || d_gnt) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                m_en    = 1'b1;
                m_we    = we_q;
                state_d = we_q ? IDLE : WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant_any) begin
                owner_q <= d_gnt;
                last_q  <= d_gnt;
                we_q    <= d_gnt ? d_we : c_we;
                addr_q  <= d_gnt ? d_addr[ADDR_W-1:2] : c_addr[ADDR_W-1:2];
                wdata_q <= d_gnt ? d_wdata : c_wdata;
            end
            if (state_q == ISSUE) begin
                cnt_q <= CNT_INIT;
            end else if ((state_q == WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            // Only the owner's data register moves; the other port keeps its last read.
            if (last_wait) begin
                if (owner_q) begin
                    d_rdata_q <= m_rdata;
                end else begin
                    c_rdata_q <= m_rdata;
                end
            end
        end
    end

    assign m_addr   = {addr_q, 2'b00};
    assign m_wdata  = wdata_q;
    assign c_rvalid = (state_q == RESP) && !owner_q;
    assign d_rvalid = (state_q == RESP) && owner_q;
    assign c_rdata  = c_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = (state_q != IDLE);
    assign owner    = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter (MEM_LAT=2 main instance, MEM_LAT=1 second instance).
// Latency: vectors wait for grant with a cycle budget; read data is checked by a scoreboard on rvalid.
// Backpressure: requests are held until the bench observes the grant, then dropped.
module tb_mem_port_arbiter;

    logic        clock;
    logic        resetn;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [31:0] c_rdata, d_rdata;
    logic        m_en, m_we, busy, owner;
    logic [31:0] m_addr, m_wdata, m_rdata;

    logic        l1_c_req, l1_c_we, l1_d_req, l1_d_we;
    logic [31:0] l1_c_addr, l1_c_wdata, l1_d_addr, l1_d_wdata;
    logic        l1_c_gnt, l1_c_rvalid, l1_d_gnt, l1_d_rvalid;
    logic [31:0] l1_c_rdata, l1_d_rdata;
    logic        l1_m_en, l1_m_we, l1_busy, l1_owner;
    logic [31:0] l1_m_addr, l1_m_wdata, l1_m_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
        .clock(clock), .resetn(resetn),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy), .owner(owner)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clock(clock), .resetn(resetn),
        .c_req(l1_c_req), .c_we(l1_c_we), .c_addr(l1_c_addr), .c_wdata(l1_c_wdata),
        .c_gnt(l1_c_gnt), .c_rvalid(l1_c_rvalid), .c_rdata(l1_c_rdata),
        .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
        .d_gnt(l1_d_gnt), .d_rvalid(l1_d_rvalid), .d_rdata(l1_d_rdata),
        .m_en(l1_m_en), .m_we(l1_m_we), .m_addr(l1_m_addr), .m_wdata(l1_m_wdata),
        .m_rdata(l1_m_rdata), .busy(l1_busy), .owner(l1_owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory models: main memory shared by both instances, separate read pipelines.
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] pipe [2];
    logic [31:0] l1_pipe;

    always @(posedge clock) begin
        pipe[0] <= (m_en && !m_we) ? mem[m_addr[9:2]] : 32'hBAD0_BAD0;
        pipe[1] <= pipe[0];
        if (m_en && m_we) mem[m_addr[9:2]] = m_wdata;
    end
    assign m_rdata = pipe[1];

    always @(posedge clock) begin
        l1_pipe <= (l1_m_en && !l1_m_we) ? mem[l1_m_addr[9:2]] : 32'hBAD1_BAD1;
    end
    assign l1_m_rdata = l1_pipe;

    // Scoreboard of expected read returns.
    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;
    exp_t        sb_q [$];
    exp_t        mon_e;
    logic [31:0] last_c, last_d;

    always @(negedge clock) begin
        if (resetn) begin
            if (c_rvalid && d_rvalid) chk("rvalid_both", 1, 0);
            if (c_rvalid || d_rvalid) begin
                if (sb_q.size() == 0) begin
                    chk("rvalid_spurious", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("rvalid_port", {31'd0, d_rvalid}, {31'd0, mon_e.port});
                    if (d_rvalid) begin
                        chk("d_rdata", d_rdata, mon_e.data);
                        chk("c_rdata_hold", c_rdata, last_c);
                        last_d = mon_e.data;
                    end else begin
                        chk("c_rdata", c_rdata, mon_e.data);
                        chk("d_rdata_hold", d_rdata, last_d);
                        last_c = mon_e.data;
                    end
                end
            end
        end
    end

    typedef struct {
        logic        c_req;
        logic        c_we;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        exp_who;
        logic [31:0] exp_maddr;
    } vec_t;

    vec_t vt [13];

    task automatic chk_all_zero(input string tag);
        chk({tag, "_c_gnt"}, {31'd0, c_gnt}, 0);
        chk({tag, "_d_gnt"}, {31'd0, d_gnt}, 0);
        chk({tag, "_c_rvalid"}, {31'd0, c_rvalid}, 0);
        chk({tag, "_d_rvalid"}, {31'd0, d_rvalid}, 0);
        chk({tag, "_m_en"}, {31'd0, m_en}, 0);
        chk({tag, "_m_we"}, {31'd0, m_we}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_owner"}, {31'd0, owner}, 0);
        chk({tag, "_m_addr"}, m_addr, 0);
        chk({tag, "_m_wdata"}, m_wdata, 0);
        chk({tag, "_c_rdata"}, c_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
    endtask

    // Drive one vector, wait for its grant, check the ISSUE cycle; returns at the ISSUE negedge.
    task automatic apply_vec(input vec_t v, input string tag);
        logic        got;
        logic        we;
        logic [31:0] a, w;
        c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr; c_wdata = v.c_wdata;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
        got = 1'b0;
        #1;
        for (int n = 0; n < 60; n++) begin
            if (c_gnt || d_gnt) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!got) begin
            chk({tag, "_gnt_timeout"}, 0, 1);
            c_req = 1'b0;
            d_req = 1'b0;
            return;
        end
        chk({tag, "_d_gnt"}, {31'd0, d_gnt}, {31'd0, v.exp_who});
        chk({tag, "_c_gnt"}, {31'd0, c_gnt}, {31'd0, !v.exp_who});
        we = v.exp_who ? v.d_we : v.c_we;
        a  = v.exp_who ? v.d_addr : v.c_addr;
        w  = v.exp_who ? v.d_wdata : v.c_wdata;
        if (we) ref_mem[a[9:2]] = w;
        else sb_q.push_back('{v.exp_who, ref_mem[a[9:2]]});
        @(posedge clock);
        #1;
        if (v.exp_who) d_req = 1'b0;
        else c_req = 1'b0;
        @(negedge clock);
        chk({tag, "_m_en"}, {31'd0, m_en}, 1);
        chk({tag, "_m_we"}, {31'd0, m_we}, {31'd0, we});
        chk({tag, "_m_addr"}, m_addr, v.exp_maddr);
        if (we) chk({tag, "_m_wdata"}, m_wdata, w);
        chk({tag, "_owner"}, {31'd0, owner}, {31'd0, v.exp_who});
        chk({tag, "_busy"}, {31'd0, busy}, 1);
    endtask

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            if (!busy && sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({tag, "_idle_timeout"}, 0, 1);
    endtask

    logic [31:0] la [3];
    int          gcyc, rcyc, ng, nr;
    logic        granted;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'hC0DE_0000 | i;
            ref_mem[i] = 32'hC0DE_0000 | i;
        end
        mem[4]     = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;
        last_c = '0;
        last_d = '0;

        //          c_req c_we c_addr        c_wdata        d_req d_we d_addr        d_wdata        who maddr
        vt[0]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 1'b0, 32'h0000_0200, 32'h0,         1'b0, 32'h0000_0100};
        vt[1]  = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         1'b1, 1'b0, 32'h0000_0200, 32'h0,         1'b1, 32'h0000_0200};
        vt[2]  = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         1'b1, 1'b0, 32'h0000_0204, 32'h0,         1'b0, 32'h0000_0104};
        vt[3]  = '{1'b1, 1'b0, 32'h0000_0108, 32'h0,         1'b1, 1'b0, 32'h0000_0204, 32'h0,         1'b1, 32'h0000_0204};
        vt[4]  = '{1'b1, 1'b0, 32'h0000_0108, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_0108};
        vt[5]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_0010};
        vt[6]  = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b1, 32'h0000_0020};
        vt[7]  = '{1'b1, 1'b1, 32'h0000_0026, 32'hA5A5_0001, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_0024};
        vt[8]  = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0000_0020, 32'h0,         1'b1, 32'h0000_0020};
        vt[9]  = '{1'b1, 1'b0, 32'h0000_0024, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_0024};
        vt[10] = '{1'b1, 1'b1, 32'h0000_0030, 32'h0F0F_3030, 1'b1, 1'b0, 32'h0000_0024, 32'h0,         1'b1, 32'h0000_0024};
        vt[11] = '{1'b1, 1'b1, 32'h0000_0030, 32'h0F0F_3030, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_0030};
        vt[12] = '{1'b1, 1'b0, 32'h0000_0031, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_0030};

        resetn = 1'b0;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        l1_c_req = 0; l1_c_we = 0; l1_c_addr = 0; l1_c_wdata = 0;
        l1_d_req = 0; l1_d_we = 0; l1_d_addr = 0; l1_d_wdata = 0;
        #1;
        chk_all_zero("reset");
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;

        // Table: alternation after reset, single-port reads/writes, misaligned addresses, read-back.
        for (int i = 0; i < 13; i++) begin
            apply_vec(vt[i], $sformatf("vec%0d", i));
        end
        wait_idle("table");

        // Single CPU read, cycle-exact.
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0000_0010;
        #1;
        chk("rd_c0_gnt", {31'd0, c_gnt}, 1);
        chk("rd_c0_busy", {31'd0, busy}, 0);
        sb_q.push_back('{1'b0, ref_mem[4]});
        @(posedge clock); #1; c_req = 1'b0;
        @(negedge clock);
        chk("rd_c1_m_en", {31'd0, m_en}, 1);
        chk("rd_c1_m_addr", m_addr, 32'h0000_0010);
        chk("rd_c1_busy", {31'd0, busy}, 1);
        @(negedge clock);
        chk("rd_c2_m_en", {31'd0, m_en}, 0);
        chk("rd_c2_busy", {31'd0, busy}, 1);
        @(negedge clock);
        chk("rd_c3_rvalid", {31'd0, c_rvalid}, 0);
        chk("rd_c3_busy", {31'd0, busy}, 1);
        @(negedge clock);
        chk("rd_c4_rvalid", {31'd0, c_rvalid}, 1);
        chk("rd_c4_rdata", c_rdata, 32'hDEAD_BEEF);
        chk("rd_c4_busy", {31'd0, busy}, 1);
        @(negedge clock);
        chk("rd_c5_busy", {31'd0, busy}, 0);
        wait_idle("cpu_read");

        // DMA write followed immediately by a second held write: next grant two cycles later.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0020; d_wdata = 32'h1234_5678;
        #1;
        chk("wr_c0_gnt", {31'd0, d_gnt}, 1);
        ref_mem[8] = 32'h1234_5678;
        @(posedge clock); #1;
        d_addr = 32'h0000_0028; d_wdata = 32'h9ABC_DEF0;
        @(negedge clock);
        chk("wr_c1_m_en", {31'd0, m_en}, 1);
        chk("wr_c1_m_we", {31'd0, m_we}, 1);
        chk("wr_c1_m_addr", m_addr, 32'h0000_0020);
        chk("wr_c1_m_wdata", m_wdata, 32'h1234_5678);
        chk("wr_c1_gnt", {31'd0, d_gnt}, 0);
        @(negedge clock);
        chk("wr_c2_busy", {31'd0, busy}, 0);
        chk("wr_c2_gnt", {31'd0, d_gnt}, 1);
        ref_mem[10] = 32'h9ABC_DEF0;
        @(posedge clock); #1; d_req = 1'b0;
        @(negedge clock);
        chk("wr_c3_m_addr", m_addr, 32'h0000_0028);
        chk("wr_c3_m_wdata", m_wdata, 32'h9ABC_DEF0);
        wait_idle("dma_write");
        chk("wr_mem_a", mem[8], 32'h1234_5678);
        chk("wr_mem_b", mem[10], 32'h9ABC_DEF0);

        // Reset during WAIT with both requests held.
        apply_vec('{1'b1, 1'b0, 32'h0000_0050, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0000_0050}, "pre_rst");
        @(negedge clock);
        c_req = 1'b1; c_addr = 32'h0000_0040; c_we = 1'b0;
        d_req = 1'b1; d_addr = 32'h0000_0044; d_we = 1'b0;
        resetn = 1'b0;
        sb_q.delete();
        last_c = '0;
        last_d = '0;
        #1;
        chk_all_zero("midrst");
        @(negedge clock);
        c_req = 1'b0;
        d_req = 1'b0;
        resetn = 1'b1;
        apply_vec('{1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 32'h0000_0040}, "post_rst_c");
        apply_vec('{1'b0, 1'b0, 32'h0,         32'h0, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b1, 32'h0000_0044}, "post_rst_d");
        wait_idle("reset");

        // MEM_LAT=1 instance: back-to-back CPU reads.
        la[0] = 32'h0000_0100; la[1] = 32'h0000_0104; la[2] = 32'h0000_0108;
        ng = 0; nr = 0; gcyc = 0; rcyc = 0;
        @(posedge clock); #1;
        l1_c_addr = la[0];
        l1_c_req  = 1'b1;
        for (int cyc = 0; cyc < 40 && nr < 3; cyc++) begin
            @(negedge clock);
            granted = 1'b0;
            if (l1_c_gnt) begin
                if (ng > 0) chk("l1_next_gnt", cyc - rcyc, 1);
                gcyc = cyc;
                granted = 1'b1;
                ng++;
            end
            if (l1_c_rvalid) begin
                chk("l1_rv_lat", cyc - gcyc, 3);
                chk("l1_rdata", l1_c_rdata, ref_mem[la[nr][9:2]]);
                rcyc = cyc;
                nr++;
            end
            @(posedge clock); #1;
            if (granted) begin
                if (ng < 3) l1_c_addr = la[ng];
                else l1_c_req = 1'b0;
            end
        end
        l1_c_req = 1'b0;
        chk("l1_reads", nr, 3);
        @(negedge clock);
        @(negedge clock);
        chk("l1_idle", {25'd0, l1_busy, l1_owner, l1_d_gnt, l1_d_rvalid, l1_m_we, |l1_m_wdata, |l1_d_rdata}, 0);

        wait_idle("final");
        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between the multicycle CPU port (fetch, load and store) and a DMA/loader port (program load and debug access).
- Each requester uses a req/gnt handshake.
- The arbiter serialises accesses onto one memory port with a fixed read latency and returns read data with a per-requester valid pulse.
- Arbitration is round-robin, so neither port can starve the other.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data word width.
- MEM_LAT, 2, cycles from the m_en cycle to the cycle m_rdata is valid (≥1).

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- c_req  in  1  CPU access request, held until c_gnt
- c_we  in  1  CPU write (1) or read (0)
- c_addr  in  ADDR_W  CPU byte address
- c_wdata  in  DATA_W  CPU write data
- c_gnt  out  1  CPU request accepted this cycle
- c_rvalid  out  1  CPU read data valid, one-cycle pulse
- c_rdata  out  DATA_W  CPU read data
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: DMA equivalents of the c_* ports, same directions and widths
- m_en  out  1  memory access strobe
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory byte address, bits [1:0] forced to 0
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data
- busy  out  1  arbiter not in IDLE
- owner  out  1  current/last owner (0 = CPU, 1 = DMA)

Behaviour:
- Interface: single clock domain. resetn is asynchronous and active-low; all state is cleared on assertion.
- Reset values:
  - state = IDLE.
  - All gnt, rvalid, m_en, m_we and busy = 0.
  - m_addr, m_wdata, c_rdata, d_rdata = 0.
  - owner = 0.
  - Round-robin pointer last = 1 (DMA), so the CPU wins the first tie.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the port that is not `last`.
  - x_gnt is combinational from the req inputs and the state, and is high only in IDLE.
  - On the granting edge, capture we/addr/wdata and the owner id, update last := granted id, and go to ISSUE.
  - With no req, stay in IDLE.
- ISSUE (one cycle): m_en = 1, m_we = captured we, m_addr = {captured addr[ADDR_W-1:2], 2'b00}, m_wdata = captured wdata.
  - Write: next state is IDLE. No rvalid is produced.
  - Read: next state is WAIT and the counter is loaded with MEM_LAT-1.
- WAIT (MEM_LAT cycles): m_en = 0. The counter decrements each cycle. On the final WAIT cycle (counter = 0), m_rdata is registered into the owner's x_rdata and the next state is RESP.
- RESP (one cycle): owner's x_rvalid = 1, then IDLE. The other port's rdata and rvalid are unaffected.
- Timing for a read granted in cycle t:
  - m_en in t+1.
  - m_rdata sampled at the end of cycle t+1+MEM_LAT.
  - rvalid in t+2+MEM_LAT.
  - Earliest next gnt in t+3+MEM_LAT.
- Timing for a write granted in cycle t: m_en/m_we in t+1; earliest next gnt in t+2.
- x_rdata holds its last value until that port's next read completes.
- Requester rules:
  - req plus fields must be stable until gnt.
  - Deasserting req after gnt has no effect on the access in progress.
  - A req dropped before gnt is simply not served.
- busy = (state != IDLE). owner is updated on grant only.
- Reset mid-transaction: the access is abandoned, no rvalid is issued, m_en drops immediately (async), and the arbiter starts in IDLE after release.
- Misaligned addresses are not an error. Low bits are silently cleared on m_addr.
- Wrap-around: the counter is internal only. Addresses pass through unmodified apart from the cleared bits [1:0].

Test Plan:
- Reset mid-read (assert resetn=0 during WAIT) -> all outputs 0 immediately. No c_rvalid after release. First subsequent tie is granted to the CPU.
- Single CPU read, MEM_LAT=2: c_req in cycle 0 with addr 0x0000_0010, memory model returns 0xDEAD_BEEF -> c_gnt cycle 0, m_en cycle 1 with m_addr 0x10, c_rvalid cycle 4 with c_rdata 0xDEAD_BEEF, busy cycles 1–4.
- DMA write: d_req, d_we=1, addr 0x20, wdata 0x1234_5678 -> d_gnt cycle 0, m_en=m_we=1 in cycle 1 with those values, no rvalid, busy low in cycle 2, next gnt possible in cycle 2.
- Simultaneous c_req and d_req held continuously for four reads -> grants alternate C, D, C, D (after reset). Each rvalid goes only to its owner. The other port's rdata is unchanged.
- Misaligned CPU read addr 0x0000_0013 -> m_addr 0x0000_0010. Data is returned normally.
- MEM_LAT=1 build, back-to-back CPU reads -> rvalid 3 cycles after gnt, next gnt 1 cycle after rvalid. Captured data matches the memory model.
